// File: rtl/pkt_pingpong_pkg.sv
// Shared types and constants for the two-buffer packet ownership controller.
package pkt_pingpong_pkg;

  localparam int NUM_BUF   = 2;
  localparam int LEN_W_DEF = 10;

  typedef enum logic [1:0] {
    B_FREE = 2'd0,
    B_FILL = 2'd1,
    B_FULL = 2'd2,
    B_READ = 2'd3
  } buf_state_t;

endpackage

// File: rtl/pkt_buf_slot.sv
// One packet buffer: ownership state plus the length latched at end of packet.
module pkt_buf_slot
  import pkt_pingpong_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             alloc,
  input  logic             done,
  input  logic             abort,
  input  logic             take,
  input  logic             rel,
  input  logic [LEN_W-1:0] len_in,
  output buf_state_t       state,
  output logic [LEN_W-1:0] len
);

  // alloc on a READ slot only arrives together with rel (release/alloc bypass).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= B_FREE;
      len   <= '0;
    end else begin
      case (state)
        B_FREE: if (alloc) state <= B_FILL;
        B_FILL: begin
          if (abort) begin
            state <= B_FREE;
          end else if (done) begin
            state <= B_FULL;
            len   <= len_in;
          end
        end
        B_FULL: if (take) state <= B_READ;
        B_READ: begin
          if (alloc)    state <= B_FILL;
          else if (rel) state <= B_FREE;
        end
        default: state <= B_FREE;
      endcase
    end
  end

endmodule

// File: rtl/pkt_pingpong_ctrl.sv
// Ping-pong ownership controller for two packet buffers between the MAC writer
// and the AXI reader; packets reach the reader in grant order.
module pkt_pingpong_ctrl
  import pkt_pingpong_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DROP_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              wr_start_i,
  output logic              wr_grant_o,
  output logic              wr_drop_o,
  output logic              wr_sel_o,
  input  logic              wr_done_i,
  input  logic              wr_abort_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  output logic              rd_valid_o,
  output logic              rd_sel_o,
  output logic [LEN_W-1:0]  rd_len_o,
  input  logic              rd_take_i,
  input  logic              rd_release_i,
  output logic [31:0]       pkt_count_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  buf_state_t       st   [NUM_BUF];
  logic [LEN_W-1:0] blen [NUM_BUF];

  logic wr_ptr, wr_hold;
  logic rd_ptr, rd_hold, rd_idx;

  logic rel_ok, start_ok, target_free;
  logic do_alloc, do_drop, do_abort, do_done, take_fire, rd_offer, new_err;

  // Handshake: an offer is accepted in any cycle where rd_valid_o & rd_take_i;
  // all other strobes are single-cycle pulses sampled on the rising ACLK edge.
  always_comb begin
    rel_ok      = rd_release_i & rd_hold;
    start_ok    = wr_start_i & ~wr_hold;
    target_free = (st[wr_ptr] == B_FREE) | (rel_ok & (rd_idx == wr_ptr));
    do_alloc    = start_ok & target_free;
    do_drop     = start_ok & ~target_free;
    do_abort    = wr_abort_i & wr_hold;
    do_done     = wr_done_i & wr_hold & ~wr_abort_i;
    take_fire   = rd_valid_o & rd_take_i;
    rd_offer    = (st[rd_ptr] == B_FULL) & ~rd_hold;
    new_err     = (wr_start_i & wr_hold)
                | ((wr_done_i | wr_abort_i) & ~wr_hold)
                | (wr_done_i & wr_abort_i)
                | (rd_release_i & ~rd_hold);
  end

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_slot
    pkt_buf_slot #(.LEN_W(LEN_W)) u_slot (
      .ACLK   (ACLK),
      .ARESETN(ARESETN),
      .alloc  (do_alloc  & (wr_ptr   == 1'(i))),
      .done   (do_done   & (wr_sel_o == 1'(i))),
      .abort  (do_abort  & (wr_sel_o == 1'(i))),
      .take   (take_fire & (rd_ptr   == 1'(i))),
      .rel    (rel_ok    & (rd_idx   == 1'(i))),
      .len_in (wr_len_i),
      .state  (st[i]),
      .len    (blen[i])
    );
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_grant_o   <= 1'b0;
      wr_drop_o    <= 1'b0;
      wr_sel_o     <= 1'b0;
      wr_ptr       <= 1'b0;
      wr_hold      <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_ptr       <= 1'b0;
      rd_hold      <= 1'b0;
      rd_idx       <= 1'b0;
      pkt_count_o  <= '0;
      drop_count_o <= '0;
      err_o        <= 1'b0;
    end else begin
      wr_grant_o <= do_alloc;
      wr_drop_o  <= do_drop;
      if (do_alloc) begin
        wr_sel_o <= wr_ptr;
        wr_hold  <= 1'b1;
        wr_ptr   <= ~wr_ptr;
      end else if (do_abort) begin
        // Hand the aborted buffer straight back to the next allocation.
        wr_hold <= 1'b0;
        wr_ptr  <= wr_sel_o;
      end else if (do_done) begin
        wr_hold <= 1'b0;
      end

      if (do_done) pkt_count_o <= pkt_count_o + 32'd1;
      if (do_drop && (drop_count_o != '1)) drop_count_o <= drop_count_o + DROP_W'(1);

      rd_valid_o <= rd_offer & ~take_fire;
      if (take_fire) begin
        rd_hold <= 1'b1;
        rd_idx  <= rd_ptr;
        rd_ptr  <= ~rd_ptr;
      end else if (rel_ok) begin
        rd_hold <= 1'b0;
      end

      err_o <= new_err | (err_o & ~err_clr_i);
    end
  end

  assign rd_sel_o = rd_hold ? rd_idx : rd_ptr;
  assign rd_len_o = blen[rd_sel_o];

endmodule

// File: doc/pkt_pingpong_ctrl.md
Name: pkt_pingpong_ctrl

Overview:
Ownership controller for the two packet output buffers (buffer 0/1) between the MAC write side and the AXI4-Lite read side. Grants a free buffer to the MAC writer at packet start and records the packet length at end of packet. Presents completed packets to the AXI reader in arrival order and frees each buffer on release. Counts accepted and dropped packets. Lives in the ACLK domain; MAC-side strobes arrive already synchronised.

Parameters:
LEN_W, 10, packet length field width in words (addr width 9 + 1)
DROP_W, 16, drop counter width (saturating)

Ports:
ACLK  in  1  block clock
ARESETN  in  1  asynchronous active-low reset
wr_start_i  in  1  pulse: writer requests a buffer for a new packet
wr_grant_o  out  1  pulse: buffer granted; wr_sel_o valid
wr_drop_o  out  1  pulse: no buffer available, packet dropped
wr_sel_o  out  1  buffer index owned by writer (held while filling)
wr_done_i  in  1  pulse: packet complete, wr_len_i valid
wr_abort_i  in  1  pulse: packet discarded, buffer returned
wr_len_i  in  LEN_W  packet length in words
rd_valid_o  out  1  completed packet available for reader
rd_sel_o  out  1  buffer index offered / owned by reader
rd_len_o  out  LEN_W  length of offered packet
rd_take_i  in  1  reader accepts offered packet (valid & take)
rd_release_i  in  1  pulse: reader finished, buffer freed
pkt_count_o  out  32  completed packets, wraps
drop_count_o  out  DROP_W  dropped packets, saturates at all-ones
err_o  out  1  sticky protocol-error flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (async assert, sync deassert handled upstream): both buffers FREE, wr_ptr=0, rd_ptr=0, all outputs 0, lengths 0, counters 0; any in-flight packet is discarded.
- Per-buffer state: FREE -> FILL (grant) -> FULL (wr_done) -> READ (take) -> FREE (release); FILL -> FREE on wr_abort.
- Strict ping-pong allocation: wr_start_i checks only buffer[wr_ptr]. If FREE: next cycle wr_grant_o=1 for one cycle, wr_sel_o=wr_ptr, buffer -> FILL, wr_ptr toggles. Otherwise: next cycle wr_drop_o=1 for one cycle, drop_count_o+1 (saturating).
- wr_start_i while writer already holds a FILL buffer: ignored, err_o set.
- wr_done_i: owned buffer -> FULL, length latched from wr_len_i, pkt_count_o+1 (wraps 0xFFFFFFFF -> 0). wr_len_i=0 accepted as-is.
- wr_abort_i: owned buffer -> FREE, wr_ptr toggles back to it; pkt_count_o unchanged. wr_done_i and wr_abort_i together: abort wins, err_o set.
- wr_done_i/wr_abort_i with no owned buffer: ignored, err_o set.
- Reader: rd_valid_o = (buffer[rd_ptr]==FULL) and reader holds nothing, registered (1 cycle after FULL). rd_sel_o=rd_ptr, rd_len_o=latched length.
- rd_valid_o & rd_take_i: buffer -> READ, rd_valid_o drops next cycle, rd_ptr toggles, rd_sel_o held at taken index until release.
- rd_release_i: READ buffer -> FREE. rd_release_i with nothing held: ignored, err_o set.
- Release/alloc bypass: rd_release_i in the same cycle as wr_start_i on the same buffer frees it first, so the grant succeeds.
- Packet order at reader always equals grant order; no reordering.
- err_o is sticky until err_clr_i; a new error in the same cycle as the clear wins (err_o stays 1).

Decomposition:
- Package pkt_pingpong_pkg: enum buf_state_t {B_FREE, B_FILL, B_FULL, B_READ} (2 bits); constant NUM_BUF=2; default LEN_W.
- Sub-module pkt_buf_slot: one buffer's state register plus latched length, with alloc/done/abort/take/release inputs and state output. Instantiated twice; the top holds the pointers, counters, error logic and pulse outputs.

Test Plan:
- Single packet: start -> grant sel=0; done len=375 -> rd_valid=1, rd_len=375, rd_sel=0; take, release -> both FREE, pkt_count=1.
- Back-to-back: 2 packets with no reads -> grants sel=0 then 1; third start -> wr_drop pulse, drop_count=1; reader sees len order 0 then 1.
- Abort: start (sel=0), abort -> buffer 0 FREE; next start grants sel=0 again; pkt_count=0.
- Bypass: both buffers used, reader releases buffer 0 in the same cycle as wr_start -> grant sel=0, no drop.
- Errors: done with no owned buffer -> err_o=1, pkt_count unchanged; err_clr -> 0; drop_count forced to 0xFFFF then one more drop -> stays 0xFFFF.
- Reset mid-packet: deassert ARESETN during FILL and READ -> all outputs 0 immediately; after reset, start grants sel=0.
